cursor_box_drawer: RTL and testbench

//  Downstream of the key-driven origin updater. Consumes xorigin/yorigin and renders a
//  BOX_SIZE x BOX_SIZE cursor on the LT24 via its pixel write handshake. Clears the screen

---
 rtl/cursor_box_drawer.sv | 216 +++++++++++++++++++++
 tb/tb_cursor_box_drawer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_box_drawer.sv
// -----------------------------------------------------------------------------
// cursor_box_drawer
//
// Renders a BOX_SIZE x BOX_SIZE cursor on the LT24 through its pixel-write
// handshake. After reset the whole screen is cleared to BG_COLOUR and the box
// is drawn at the current origin. Afterwards, whenever the requested origin
// differs from the drawn one, the old box is erased in BG_COLOUR and the box is
// redrawn in FG_COLOUR at the newly latched origin.
//
// Ports
//   clock       in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high
//   xorigin     in   8   requested box origin x (top-left corner)
//   yorigin     in   9   requested box origin y
//   pixelReady  in   1   LT24 driver accepts the presented pixel this cycle
//   xAddr       out  8   pixel x address
//   yAddr       out  9   pixel y address
//   pixelData   out  16  pixel colour, RGB565
//   pixelWrite  out  1   pixel request valid (held until accepted)
//   busy        out  1   high while a clear/erase/draw pass runs
//   drawDone    out  1   one-cycle pulse when a draw pass completes
// -----------------------------------------------------------------------------
module cursor_box_drawer #(
    parameter int unsigned SCREEN_W  = 240,
    parameter int unsigned SCREEN_H  = 320,
    parameter int unsigned BOX_SIZE  = 4,
    parameter logic [15:0] FG_COLOUR = 16'hF800,
    parameter logic [15:0] BG_COLOUR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  xorigin,
    input  logic [8:0]  yorigin,
    input  logic        pixelReady,
    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    output logic        busy,
    output logic        drawDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ERASE = 2'd2,
        DRAW  = 2'd3
    } state_t;

    localparam logic [8:0] CLR_COL_LAST = 9'(SCREEN_W - 1);
    localparam logic [8:0] CLR_ROW_LAST = 9'(SCREEN_H - 1);
    localparam logic [8:0] BOX_LAST     = 9'(BOX_SIZE - 1);
    localparam logic [9:0] SCREEN_W_10  = 10'(SCREEN_W);
    localparam logic [9:0] SCREEN_H_10  = 10'(SCREEN_H);

    state_t      state_q;
    logic [8:0]  col_q;
    logic [8:0]  row_q;
    // Set once the last pixel of the pass has been presented; the pass ends on
    // the first free cycle after that (i.e. once that pixel is accepted).
    logic        issued_q;
    logic [7:0]  cur_x_q;
    logic [8:0]  cur_y_q;

    logic [7:0]  x_addr_q;
    logic [8:0]  y_addr_q;
    logic [15:0] pixel_data_q;
    logic        pixel_write_q;
    logic        busy_q;
    logic        draw_done_q;

    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        clipped;
    logic        col_last;
    logic        row_last;
    logic [8:0]  col_nxt;
    logic [8:0]  row_nxt;
    logic        last_pix;
    logic        free;
    logic [15:0] colour;
    logic        origin_moved;

    // Box addresses are formed 10 bits wide so an origin near the right/bottom
    // edge runs off-screen and gets clipped instead of wrapping back to 0.
    assign box_x = {2'b00, cur_x_q} + {1'b0, col_q};
    assign box_y = {1'b0, cur_y_q} + {1'b0, row_q};

    always_comb begin
        pix_x    = box_x;
        pix_y    = box_y;
        col_last = (col_q == BOX_LAST);
        row_last = (row_q == BOX_LAST);
        if (state_q == CLEAR) begin
            pix_x    = {1'b0, col_q};
            pix_y    = {1'b0, row_q};
            col_last = (col_q == CLR_COL_LAST);
            row_last = (row_q == CLR_ROW_LAST);
        end
    end

    assign clipped = (pix_x >= SCREEN_W_10) || (pix_y >= SCREEN_H_10);

    // Scan order: x fastest, then y.
    always_comb begin
        col_nxt  = col_q + 9'd1;
        row_nxt  = row_q;
        last_pix = 1'b0;
        if (col_last) begin
            col_nxt = 9'd0;
            if (row_last) begin
                row_nxt  = 9'd0;
                last_pix = 1'b1;
            end else begin
                row_nxt = row_q + 9'd1;
            end
        end
    end

    // The output slot can take a new pixel when nothing is pending or the
    // pending pixel is accepted this cycle.
    assign free         = !pixel_write_q || pixelReady;
    assign colour       = (state_q == DRAW) ? FG_COLOUR : BG_COLOUR;
    assign origin_moved = ({xorigin, yorigin} != {cur_x_q, cur_y_q});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= CLEAR;
            col_q         <= 9'd0;
            row_q         <= 9'd0;
            issued_q      <= 1'b0;
            cur_x_q       <= 8'd0;
            cur_y_q       <= 9'd0;
            x_addr_q      <= 8'd0;
            y_addr_q      <= 9'd0;
            pixel_data_q  <= 16'd0;
            pixel_write_q <= 1'b0;
            busy_q        <= 1'b0;
            draw_done_q   <= 1'b0;
        end else begin
            draw_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pixel_write_q <= 1'b0;
                    busy_q        <= 1'b0;
                    // Present the first erase pixel straight away so the
                    // request appears one cycle after the change is seen.
                    if (origin_moved) begin
                        state_q       <= ERASE;
                        busy_q        <= 1'b1;
                        pixel_write_q <= !clipped;
                        if (!clipped) begin
                            x_addr_q     <= pix_x[7:0];
                            y_addr_q     <= pix_y[8:0];
                            pixel_data_q <= BG_COLOUR;
                        end
                        col_q    <= col_nxt;
                        row_q    <= row_nxt;
                        issued_q <= last_pix;
                    end
                end

                CLEAR, ERASE, DRAW: begin
                    busy_q <= 1'b1;
                    if (free) begin
                        if (issued_q) begin
                            // Pass complete: one cycle with no request while
                            // the next pass is set up.
                            pixel_write_q <= 1'b0;
                            col_q         <= 9'd0;
                            row_q         <= 9'd0;
                            issued_q      <= 1'b0;
                            if (state_q == DRAW) begin
                                state_q     <= IDLE;
                                busy_q      <= 1'b0;
                                draw_done_q <= 1'b1;
                            end else begin
                                state_q <= DRAW;
                                cur_x_q <= xorigin;
                                cur_y_q <= yorigin;
                            end
                        end else begin
                            // An off-screen pixel still consumes one cycle,
                            // just without a request.
                            pixel_write_q <= !clipped;
                            if (!clipped) begin
                                x_addr_q     <= pix_x[7:0];
                                y_addr_q     <= pix_y[8:0];
                                pixel_data_q <= colour;
                            end
                            col_q    <= col_nxt;
                            row_q    <= row_nxt;
                            issued_q <= last_pix;
                        end
                    end
                end

                default: begin
                    state_q       <= IDLE;
                    pixel_write_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign xAddr      = x_addr_q;
    assign yAddr      = y_addr_q;
    assign pixelData  = pixel_data_q;
    assign pixelWrite = pixel_write_q;
    assign busy       = busy_q;
    assign drawDone   = draw_done_q;

endmodule

// File: tb/tb_cursor_box_drawer.sv
// -----------------------------------------------------------------------------
// tb_cursor_box_drawer
//
// Bench for cursor_box_drawer on a small 8x4 screen with a 4x4 box. The bench
// keeps a queue of the pixel writes the screen rules demand (clear scan, erase
// box, draw box, off-screen pixels removed) plus a frame buffer, and checks
// every accepted beat, held request and drawDone pulse against it.
// -----------------------------------------------------------------------------
module tb_cursor_box_drawer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = 4;
    localparam logic [15:0] FG = 16'hF800;
    localparam logic [15:0] BG = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  xorigin;
    logic [8:0]  yorigin;
    logic        pixelReady;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        busy;
    logic        drawDone;

    always #5 clk = ~clk;

    cursor_box_drawer #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .BOX_SIZE (N),
        .FG_COLOUR(FG),
        .BG_COLOUR(BG)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .xorigin   (xorigin),
        .yorigin   (yorigin),
        .pixelReady(pixelReady),
        .xAddr     (xAddr),
        .yAddr     (yAddr),
        .pixelData (pixelData),
        .pixelWrite(pixelWrite),
        .busy      (busy),
        .drawDone  (drawDone)
    );

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
    } pix_t;

    pix_t        exp_q[$];
    logic [15:0] fb[H][W];
    int checks   = 0;
    int errors   = 0;
    int beats    = 0;
    int fg_beats = 0;
    int holds    = 0;
    int exp_done = 0;
    int rcnt     = 0;
    bit ready_mode = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- model: expected write sequences ----------------
    task automatic push_pix(input int x, input int y, input logic [15:0] c);
        pix_t p;
        p.x = 8'(x);
        p.y = 9'(y);
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic push_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                push_pix(x, y, BG);
    endtask

    task automatic push_box(input int ox, input int oy, input logic [15:0] c);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++)
                if (ox + k < W && oy + r < H)
                    push_pix(ox + k, oy + r, c);
    endtask

    // ---------------- compare process ----------------
    logic        prev_pend = 1'b0;
    logic [7:0]  prev_x;
    logic [8:0]  prev_y;
    logic [15:0] prev_c;

    always @(negedge clk) begin
        pix_t e;
        if (!reset) begin
            if (prev_pend) begin
                holds++;
                chk("hold_write", int'(pixelWrite), 1);
                chk("hold_x", int'(xAddr), int'(prev_x));
                chk("hold_y", int'(yAddr), int'(prev_y));
                chk("hold_c", int'(pixelData), int'(prev_c));
            end
            if (pixelWrite) begin
                chk("x_range", int'(int'(xAddr) < W), 1);
                chk("y_range", int'(int'(yAddr) < H), 1);
                chk("busy_on_write", int'(busy), 1);
                if (pixelReady) begin
                    beats++;
                    if (pixelData == FG) fg_beats++;
                    if (int'(xAddr) < W && int'(yAddr) < H)
                        fb[int'(yAddr)][int'(xAddr)] = pixelData;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_x", int'(xAddr), int'(e.x));
                        chk("beat_y", int'(yAddr), int'(e.y));
                        chk("beat_c", int'(pixelData), int'(e.c));
                    end
                end
            end
            if (drawDone) begin
                chk("done_expected", int'(exp_done > 0), 1);
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_busy", int'(busy), 0);
                if (exp_done > 0) exp_done--;
            end
        end
        prev_pend = !reset && pixelWrite && !pixelReady;
        prev_x    = xAddr;
        prev_y    = yAddr;
        prev_c    = pixelData;
    end

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                rcnt++;
                pixelReady = (rcnt % 3 == 0);
            end else begin
                pixelReady = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!drawDone && cyc < bound);
        if (!drawDone) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_xAddr"}, int'(xAddr), 0);
        chk({tag, "_yAddr"}, int'(yAddr), 0);
        chk({tag, "_pixelData"}, int'(pixelData), 0);
        chk({tag, "_pixelWrite"}, int'(pixelWrite), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_drawDone"}, int'(drawDone), 0);
    endtask

    initial begin
        int cyc;
        int b0;
        int f0;
        reset      = 1'b1;
        pixelReady = 1'b1;
        xorigin    = 8'd0;
        yorigin    = 9'd0;
        repeat (2) tick();
        chk_outputs_zero("rst");

        // 1: clear then draw at (0,0)
        push_clear();
        push_box(0, 0, FG);
        exp_done = 1;
        b0 = beats;
        reset = 1'b0;
        tick();
        chk("t1_first_write", int'(pixelWrite), 1);
        chk("t1_first_x", int'(xAddr), 0);
        chk("t1_first_y", int'(yAddr), 0);
        wait_done(200, cyc);
        chk("t1_beats", beats - b0, 48);

        // 2: move x to 2, latency and resulting screen
        repeat (3) tick();
        b0 = beats;
        xorigin = 8'd2;
        push_box(0, 0, BG);
        push_box(2, 0, FG);
        exp_done = 1;
        wait_done(200, cyc);
        chk("t2_latency", cyc, 34);
        chk("t2_beats", beats - b0, 32);
        repeat (2) tick();
        chk("t2_busy_idle", int'(busy), 0);
        chk("t2_fb_x1y0", int'(fb[0][1]), 0);
        chk("t2_fb_x2y0", int'(fb[0][2]), 16'hF800);
        chk("t2_fb_x5y3", int'(fb[3][5]), 16'hF800);
        chk("t2_fb_x6y3", int'(fb[3][6]), 0);

        // 4: stalled handshake, 1-in-3 ready
        repeat (3) tick();
        b0 = beats;
        ready_mode = 1'b1;
        xorigin = 8'd4;
        push_box(2, 0, BG);
        push_box(4, 0, FG);
        exp_done = 1;
        wait_done(400, cyc);
        ready_mode = 1'b0;
        chk("t4_beats", beats - b0, 32);
        chk("t4_stalls_seen", int'(holds > 0), 1);

        // 3: clipping at the right/bottom corner
        repeat (3) tick();
        f0 = fg_beats;
        xorigin = 8'd7;
        yorigin = 9'd2;
        push_box(4, 0, BG);
        push_box(7, 2, FG);
        exp_done = 1;
        wait_done(200, cyc);
        chk("t3_fg_writes", fg_beats - f0, 2);
        chk("t3_fb_x7y2", int'(fb[2][7]), 16'hF800);
        chk("t3_fb_x7y3", int'(fb[3][7]), 16'hF800);

        // origin far past the edge: nothing drawn, no wrap to column 0
        repeat (3) tick();
        b0 = beats;
        xorigin = 8'd254;
        yorigin = 9'd0;
        push_box(7, 2, BG);
        push_box(254, 0, FG);
        exp_done = 1;
        wait_done(200, cyc);
        chk("t3_wrap_beats", beats - b0, 2);

        repeat (3) tick();
        b0 = beats;
        xorigin = 8'd0;
        push_box(254, 0, BG);
        push_box(0, 0, FG);
        exp_done = 1;
        wait_done(200, cyc);
        chk("t3_back_beats", beats - b0, 16);

        // 5: origin changes during erase; draw uses value at erase end
        repeat (3) tick();
        b0 = beats;
        yorigin = 9'd1;
        push_box(0, 0, BG);
        push_box(0, 2, FG);
        exp_done = 1;
        repeat (4) tick();
        yorigin = 9'd2;
        wait_done(200, cyc);
        chk("t5_beats", beats - b0, 24);
        b0 = beats;
        repeat (20) tick();
        chk("t5_no_extra_busy", int'(busy), 0);
        chk("t5_no_extra_beats", beats - b0, 0);

        // 6: reset in the middle of a draw pass
        repeat (3) tick();
        b0 = beats;
        yorigin = 9'd0;
        push_box(0, 2, BG);
        push_box(0, 0, FG);
        exp_done = 1;
        cyc = 0;
        while (beats - b0 < 11 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("t6_reached_draw", int'(beats - b0 >= 11), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        push_clear();
        push_box(0, 0, FG);
        exp_done = 1;
        chk_outputs_zero("t6_rst");
        tick();
        chk("t6_restart_write", int'(pixelWrite), 1);
        chk("t6_restart_x", int'(xAddr), 0);
        chk("t6_restart_y", int'(yAddr), 0);
        wait_done(300, cyc);
        repeat (3) tick();
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_done_pending", exp_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
